// File: rtl/mod53_chunk_reducer.sv
// Reduces a 6*N_CHUNKS-bit unsigned operand modulo 53, one 6-bit chunk per cycle
// (MS chunk first), using an external table that returns (r*64) mod 53.
module mod53_chunk_reducer #(
  parameter int N_CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6*N_CHUNKS-1:0]   in_data,
  output logic [5:0]              lut_addr,
  input  logic [5:0]              lut_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [5:0]              out_res,
  output logic                    busy
);

  localparam int W  = 6 * N_CHUNKS;
  localparam int CW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_shift;
  logic [5:0]     r_res;
  logic [CW-1:0]  r_cnt;

  logic [5:0]     w_chunk;
  logic [6:0]     w_sum;
  logic [5:0]     w_res_next;
  logic           w_last;
  logic           w_accept;

  assign w_chunk  = r_shift[W-1 -: 6];
  assign w_sum    = {1'b0, lut_data} + {1'b0, w_chunk};
  assign w_last   = (r_cnt == CW'(N_CHUNKS - 1));
  assign w_accept = (r_state == S_IDLE) && in_valid;

  // The sum never exceeds 115, so at most two subtractions of 53 bring it into range.
  always_comb begin
    w_res_next = w_sum[5:0];
    if (w_sum >= 7'd106) begin
      w_res_next = 6'(w_sum - 7'd106);
    end else if (w_sum >= 7'd53) begin
      w_res_next = 6'(w_sum - 7'd53);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= in_data;
      r_res   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_shift <= r_shift << 6;
      r_res   <= w_res_next;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_RUN) || (r_state == S_DONE);
    lut_addr  = r_res;
    out_res   = r_res;
  end

endmodule

// File: tb/tb_mod53_chunk_reducer.sv
// Randomised and directed bench for mod53_chunk_reducer with a cycle-level
// reference built from prefix-modulo arithmetic and an external table model.
module tb_mod53_chunk_reducer;

  localparam int N = 4;
  localparam int W = 6 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [5:0]   lut_addr;
  logic [5:0]   lut_data;
  logic         out_valid;
  logic         out_ready;
  logic [5:0]   out_res;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mod53_chunk_reducer #(.N_CHUNKS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .busy      (busy)
  );

  // External table: (addr * 64) mod 53
  always_comb lut_data = 6'((int'(lut_addr) * 64) % 53);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Residue of the k most significant chunks of the operand, mod 53.
  function automatic logic [5:0] prefix_mod(input logic [W-1:0] op, input int k);
    longint v;
    v = longint'(op) >> (6 * (N - k));
    return 6'(v % 53);
  endfunction

  // Reference model: an accepted operand spends N cycles stepping, then holds
  // its full-operand residue until the consumer takes it.
  bit           m_active  = 1'b0;
  int           m_elapsed = 0;
  logic [W-1:0] m_op      = '0;
  logic [5:0]   m_r       = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_r      <= '0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active  <= 1'b1;
        m_elapsed <= 0;
        m_op      <= in_data;
        m_r       <= '0;
      end
    end else if (m_elapsed < N) begin
      m_elapsed <= m_elapsed + 1;
      m_r       <= prefix_mod(m_op, m_elapsed + 1);
    end else if (out_ready) begin
      m_active <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  int'(in_ready),  int'(!m_active));
      check("busy",      int'(busy),      int'(m_active));
      check("out_valid", int'(out_valid), int'(m_active && m_elapsed == N));
      check("lut_addr",  int'(lut_addr),  int'(m_r));
      if (m_active && m_elapsed == N) begin
        check("out_res_model", int'(out_res), int'(m_op % W'(53)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Accept one operand, record lut_addr per step, check latency and literal result.
  task automatic run_op(input logic [W-1:0] data, input int exp, output int seq [0:7]);
    int cycles;
    for (int i = 0; i < 8; i++) seq[i] = -1;
    in_valid = 1'b1;
    in_data  = data;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      seq[cycles] = int'(lut_addr);
      tick();
      cycles++;
    end
    check("latency", cycles, N);
    check("out_res_lit", int'(out_res), exp);
    check("lut_addr_final", int'(lut_addr), exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_take", int'(in_ready), 1);
  endtask

  initial begin
    int seq [0:7];
    int last;
    int bound;
    logic [5:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) tick();
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_res",   int'(out_res),   0);
    check("rst_lut_addr",  int'(lut_addr),  0);
    check("rst_busy",      int'(busy),      0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    run_op(24'h000000, 0, seq);
    run_op(24'h000034, 52, seq);
    run_op(24'h000035, 0, seq);
    run_op(24'h0F4240, 49, seq);
    run_op(24'hFFFFFF, 12, seq);
    check("ff_seq0", seq[0], 0);
    check("ff_seq1", seq[1], 10);
    check("ff_seq2", seq[2], 14);
    check("ff_seq3", seq[3], 5);

    // Back-to-back with both handshakes held high
    last = -1;
    for (int c = 0; c < 40; c++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = W'($urandom);
      if (in_ready) begin
        if (last >= 0) check("b2b_gap", c - last, N + 2);
        last = c;
      end
      tick();
    end
    in_valid = 1'b0;
    bound = 0;
    while (!in_ready && bound < 20) begin
      tick();
      bound++;
    end
    check("b2b_drain", int'(in_ready), 1);
    out_ready = 1'b0;

    // Consumer stall in DONE
    in_valid = 1'b1;
    in_data  = 24'h0F4240;
    tick();
    in_valid = 1'b0;
    bound = 0;
    while (!out_valid && bound < 20) begin
      tick();
      bound++;
    end
    check("stall_reach_done", int'(out_valid), 1);
    held = out_res;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      tick();
      check("stall_valid", int'(out_valid), 1);
      check("stall_res", int'(out_res), int'(held));
      check("stall_in_ready", int'(in_ready), 0);
    end
    check("stall_res_lit", int'(held), 49);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_release_idle", int'(in_ready), 1);
    check("stall_release_valid", int'(out_valid), 0);

    // Reset during the 2nd RUN cycle
    in_valid = 1'b1;
    in_data  = 24'hFFFFFF;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_run_idle", int'(in_ready), 1);
    check("rst_run_valid", int'(out_valid), 0);
    check("rst_run_lut", int'(lut_addr), 0);
    check("rst_run_busy", int'(busy), 0);
    run_op(24'hFFFFFF, 12, seq);

    // Randomised traffic, checked every cycle by the reference model
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       in_data = '1;
        1:       in_data = W'($urandom_range(0, 106));
        default: in_data = W'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
